// File: rtl/vga_draw_pkg.sv
// Shared types and constants for the VGA panel drawers: FSM states,
// coordinate/colour types, the palette and the screen limits.
package vga_draw_pkg;

  typedef logic [9:0] x_t;
  typedef logic [8:0] y_t;
  typedef logic [8:0] color_t;

  // Frame sequencer states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_SNAP  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_ARM   = 3'd3,
    ST_DRAW  = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_e;

  // RRRGGGBBB palette used by the panels.
  typedef enum logic [8:0] {
    COLOR_BG    = 9'h000,
    COLOR_DATA  = 9'h038,
    COLOR_LABEL = 9'h1C0
  } palette_e;

  // Visible screen size; any rectangle handed to a scanner must fit inside.
  typedef enum logic [9:0] {
    SCREEN_H = 10'd480,
    SCREEN_W = 10'd640
  } screen_limit_e;

endpackage

// File: rtl/rect_fill_scanner.sv
// Raster scanner for a solid rectangle. A start pulse arms it; afterwards it
// presents one pixel per cycle in raster order (x fastest) and flags the last
// one with done. The caller registers x/y/color/plot on its own clock edge.
module rect_fill_scanner
  import vga_draw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] x0,
  input  logic [8:0] y0,
  input  logic [9:0] w,
  input  logic [8:0] h,
  input  logic [8:0] color_in,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [8:0] color,
  output logic       plot,
  output logic       done
);

  x_t   cx_q, cx_d;
  y_t   cy_q, cy_d;
  logic active_q, active_d;
  logic last_col;
  logic last_px;

  assign last_col = (cx_q == w - 10'd1);
  assign last_px  = last_col && (cy_q == h - 9'd1);

  // Cursor advance: start re-arms at the origin; the last pixel parks the
  // scanner idle with the cursor back at the origin.
  always_comb begin
    cx_d     = cx_q;
    cy_d     = cy_q;
    active_d = active_q;
    if (start) begin
      cx_d     = '0;
      cy_d     = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (last_px) begin
        cx_d     = '0;
        cy_d     = '0;
        active_d = 1'b0;
      end else if (last_col) begin
        cx_d = '0;
        cy_d = cy_q + 9'd1;
      end else begin
        cx_d = cx_q + 10'd1;
      end
    end
  end

  // Cursor and activity registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q     <= '0;
      cy_q     <= '0;
      active_q <= 1'b0;
    end else begin
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      active_q <= active_d;
    end
  end

  // Sums wrap at the port width; the caller keeps the rectangle on screen.
  assign x     = x0 + cx_q;
  assign y     = y0 + cy_q;
  assign color = color_in;
  assign plot  = active_q;
  assign done  = active_q && last_px;

endmodule

// File: rtl/pipeline_frame_sequencer.sv
// Frame sequencer for the pipeline text panel: once per refresh period it
// freezes the five stage values, clears the panel rectangle, restarts the
// drawer and forwards the drawer's pixels to the VGA adapter.
//
// Drawer stream: while drawer_resetn is high and pipeline_done is low, every
// cycle carries one valid pixel on pipeline_x/y/color; there is no
// back-pressure, so each such pixel is forwarded to vga_* on the next edge
// with vga_plot=1. pipeline_done high ends the stream (ignored on the first
// DRAW cycle while the drawer settles out of reset).
module pipeline_frame_sequencer
  import vga_draw_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 833333,
  parameter int unsigned CLEAR_X0       = 300,
  parameter int unsigned CLEAR_Y0       = 25,
  parameter int unsigned CLEAR_W        = 100,
  parameter int unsigned CLEAR_H        = 70,
  parameter logic [8:0]  BG_COLOR       = COLOR_BG,
  parameter int unsigned DRAW_TIMEOUT   = 4096
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        force_refresh,
  input  logic [31:0] IF_PC_VALUE,
  input  logic [31:0] ID_VAL_A,
  input  logic [31:0] EX_ALU_RESULT,
  input  logic [31:0] MEM_DATA_OUT,
  input  logic [31:0] WB_DATA_IN,
  output logic [31:0] snap_if,
  output logic [31:0] snap_id,
  output logic [31:0] snap_ex,
  output logic [31:0] snap_mem,
  output logic [31:0] snap_wb,
  output logic        drawer_resetn,
  input  logic [9:0]  pipeline_x,
  input  logic [8:0]  pipeline_y,
  input  logic [8:0]  pipeline_color,
  input  logic        pipeline_done,
  output logic [9:0]  vga_x,
  output logic [8:0]  vga_y,
  output logic [8:0]  vga_color,
  output logic        vga_plot,
  output logic        frame_done,
  output logic        draw_timeout,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam int RC_W = $clog2(REFRESH_CYCLES + 1);
  localparam int TO_W = $clog2(DRAW_TIMEOUT + 1);

  seq_state_e    state_q;
  logic [RC_W-1:0] refresh_cnt_q;
  logic [TO_W-1:0] timeout_cnt_q;
  logic          pending_q;
  logic [31:0]   snap_if_q, snap_id_q, snap_ex_q, snap_mem_q, snap_wb_q;
  logic          drawer_resetn_q;
  x_t            vga_x_q;
  y_t            vga_y_q;
  color_t        vga_color_q;
  logic          vga_plot_q;
  logic          frame_done_q;
  logic          draw_timeout_q;
  logic          busy_q;

  logic          scan_start;
  x_t            scan_x;
  y_t            scan_y;
  color_t        scan_color;
  logic          scan_plot;
  logic          scan_done;
  logic          draw_first;

  assign scan_start = (state_q == ST_SNAP);
  assign draw_first = (timeout_cnt_q == '0);

  rect_fill_scanner u_clear (
    .clk      (clock),
    .rst_n    (resetn),
    .start    (scan_start),
    .x0       (10'(CLEAR_X0)),
    .y0       (9'(CLEAR_Y0)),
    .w        (10'(CLEAR_W)),
    .h        (9'(CLEAR_H)),
    .color_in (BG_COLOR),
    .x        (scan_x),
    .y        (scan_y),
    .color    (scan_color),
    .plot     (scan_plot),
    .done     (scan_done)
  );

  // Frame FSM with all outputs registered. vga_* carry the write decided in
  // the previous cycle; busy, drawer_resetn and frame_done track the state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_WAIT;
      refresh_cnt_q   <= '0;
      timeout_cnt_q   <= '0;
      pending_q       <= 1'b0;
      snap_if_q       <= '0;
      snap_id_q       <= '0;
      snap_ex_q       <= '0;
      snap_mem_q      <= '0;
      snap_wb_q       <= '0;
      drawer_resetn_q <= 1'b0;
      vga_x_q         <= '0;
      vga_y_q         <= '0;
      vga_color_q     <= '0;
      vga_plot_q      <= 1'b0;
      frame_done_q    <= 1'b0;
      draw_timeout_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      vga_plot_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_WAIT: begin
          if (refresh_cnt_q == RC_W'(REFRESH_CYCLES - 1) || force_refresh || pending_q) begin
            refresh_cnt_q <= '0;
            busy_q        <= 1'b1;
            state_q       <= ST_SNAP;
          end else begin
            refresh_cnt_q <= refresh_cnt_q + 1'b1;
          end
        end
        ST_SNAP: begin
          snap_if_q  <= IF_PC_VALUE;
          snap_id_q  <= ID_VAL_A;
          snap_ex_q  <= EX_ALU_RESULT;
          snap_mem_q <= MEM_DATA_OUT;
          snap_wb_q  <= WB_DATA_IN;
          pending_q  <= 1'b0;
          state_q    <= ST_CLEAR;
        end
        ST_CLEAR: begin
          vga_x_q     <= scan_x;
          vga_y_q     <= scan_y;
          vga_color_q <= scan_color;
          vga_plot_q  <= scan_plot;
          if (scan_done) begin
            state_q <= ST_ARM;
          end
        end
        ST_ARM: begin
          drawer_resetn_q <= 1'b1;
          timeout_cnt_q   <= '0;
          state_q         <= ST_DRAW;
        end
        ST_DRAW: begin
          if (pipeline_done && !draw_first) begin
            drawer_resetn_q <= 1'b0;
            frame_done_q    <= 1'b1;
            state_q         <= ST_DONE;
          end else if (timeout_cnt_q == TO_W'(DRAW_TIMEOUT - 1)) begin
            draw_timeout_q  <= 1'b1;
            drawer_resetn_q <= 1'b0;
            frame_done_q    <= 1'b1;
            state_q         <= ST_DONE;
          end else begin
            if (!pipeline_done) begin
              vga_x_q     <= pipeline_x;
              vga_y_q     <= pipeline_y;
              vga_color_q <= pipeline_color;
              vga_plot_q  <= 1'b1;
            end
            timeout_cnt_q <= timeout_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_WAIT;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_WAIT;
        end
      endcase
      // A request during a frame is remembered (overriding the SNAP clear)
      // and served right after DONE; a request in WAIT starts SNAP directly.
      if (force_refresh && state_q != ST_WAIT) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign snap_if       = snap_if_q;
  assign snap_id       = snap_id_q;
  assign snap_ex       = snap_ex_q;
  assign snap_mem      = snap_mem_q;
  assign snap_wb       = snap_wb_q;
  assign drawer_resetn = drawer_resetn_q;
  assign vga_x         = vga_x_q;
  assign vga_y         = vga_y_q;
  assign vga_color     = vga_color_q;
  assign vga_plot      = vga_plot_q;
  assign frame_done    = frame_done_q;
  assign draw_timeout  = draw_timeout_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pipeline_frame_sequencer.sv
// Bench for pipeline_frame_sequencer: drawer model, plot scoreboard and a
// linear sequence of directed frame scenarios.
module tb_pipeline_frame_sequencer;

  localparam int RC = 20;
  localparam int X0 = 300;
  localparam int Y0 = 25;
  localparam int CW = 4;
  localparam int CH = 3;
  localparam int TO = 64;

  // Clock / reset and DUT signals
  logic        clock = 1'b0;
  logic        resetn;
  logic        force_refresh;
  logic [31:0] if_pc, id_a, ex_r, mem_d, wb_d;
  logic [31:0] snap_if, snap_id, snap_ex, snap_mem, snap_wb;
  logic        drawer_resetn;
  logic [9:0]  pipeline_x;
  logic [8:0]  pipeline_y, pipeline_color;
  logic        pipeline_done;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y, vga_color;
  logic        vga_plot, frame_done, draw_timeout, busy;
  logic [2:0]  dbg_state;

  always #5 clock = ~clock;

  pipeline_frame_sequencer #(
    .REFRESH_CYCLES (RC),
    .CLEAR_X0       (X0),
    .CLEAR_Y0       (Y0),
    .CLEAR_W        (CW),
    .CLEAR_H        (CH),
    .BG_COLOR       (9'h000),
    .DRAW_TIMEOUT   (TO)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .force_refresh  (force_refresh),
    .IF_PC_VALUE    (if_pc),
    .ID_VAL_A       (id_a),
    .EX_ALU_RESULT  (ex_r),
    .MEM_DATA_OUT   (mem_d),
    .WB_DATA_IN     (wb_d),
    .snap_if        (snap_if),
    .snap_id        (snap_id),
    .snap_ex        (snap_ex),
    .snap_mem       (snap_mem),
    .snap_wb        (snap_wb),
    .drawer_resetn  (drawer_resetn),
    .pipeline_x     (pipeline_x),
    .pipeline_y     (pipeline_y),
    .pipeline_color (pipeline_color),
    .pipeline_done  (pipeline_done),
    .vga_x          (vga_x),
    .vga_y          (vga_y),
    .vga_color      (vga_color),
    .vga_plot       (vga_plot),
    .frame_done     (frame_done),
    .draw_timeout   (draw_timeout),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // Counters and scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [27:0] exp_q[$];
  int          exp_cyc_q[$];
  int cyc      = 0;
  int plot_cnt = 0;
  int fd_cnt   = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drawer model: pixel i of a frame, presented while out of reset
  int idx   = 0;
  int n_pix = 5;
  bit hang  = 1'b0;

  function automatic logic [27:0] draw_pix(input int i);
    logic [9:0] px;
    logic [8:0] py;
    logic [8:0] pc;
    px = 10'(310 + i);
    py = 9'(30 + i / 8);
    pc = (i == 0) ? 9'h1C0 : 9'(i * 7 + 1);
    return {px, py, pc};
  endfunction

  assign {pipeline_x, pipeline_y, pipeline_color} = draw_pix(idx);
  assign pipeline_done = !hang && (idx >= n_pix);

  // Each presented pixel must reach the adapter one cycle later, except the
  // cycle in which the draw timeout fires.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!drawer_resetn) begin
      idx <= 0;
    end else if (!pipeline_done) begin
      if (idx < TO - 1) begin
        exp_q.push_back(draw_pix(idx));
        exp_cyc_q.push_back(cyc + 1);
      end
      idx <= idx + 1;
    end
  end

  // Monitor: a new frame queues its clear rectangle; every plot is scored
  always @(negedge clock) begin
    if (busy && !prev_busy) begin
      for (int yy = 0; yy < CH; yy++) begin
        for (int xx = 0; xx < CW; xx++) begin
          exp_q.push_back({10'(X0 + xx), 9'(Y0 + yy), 9'h000});
          exp_cyc_q.push_back(-1);
        end
      end
    end
    prev_busy = busy;
    if (frame_done) fd_cnt++;
    if (vga_plot) begin
      logic [27:0] e;
      int ec;
      plot_cnt++;
      check("plot_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("plot_xyc", {vga_x, vga_y, vga_color}, e);
        if (ec >= 0) check("draw_latency", cyc, ec);
      end
    end
  end

  // Driver / wait helpers (all bounded)
  task automatic measure_idle(output int cnt, output bit ok);
    cnt = 0;
    ok  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (busy) begin
        ok = 1'b1;
        break;
      end
      cnt++;
    end
  endtask

  task automatic wait_frame_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_draw(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (drawer_resetn) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int cnt;
    bit ok;
    int dc;
    int pc;
    resetn = 1'b0;
    force_refresh = 1'b0;
    if_pc = 32'h0000_1234; id_a = 32'h0; ex_r = 32'h0; mem_d = 32'h0; wb_d = 32'h0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_drawer_resetn", drawer_resetn, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_draw_timeout", draw_timeout, 0);
    check("rst_snap_if", snap_if, 0);
    check("rst_vga_xy", {vga_x, vga_y, vga_color}, 0);
    check("rst_state", dbg_state, 0);

    // First frame after release: idle for RC-1 cycles, then SNAP
    resetn = 1'b1;
    measure_idle(cnt, ok);
    check("first_snap_seen", ok, 1);
    check("idle_after_release", cnt, RC - 1);
    if_pc = 32'h0000_0040; id_a = 32'hA1A1_0001; ex_r = 32'hE3E3_0003;
    mem_d = 32'hCAFE_0004; wb_d = 32'h5555_0005;
    @(negedge clock);
    if_pc = 32'hDEAD_BEEF; id_a = 32'h0; ex_r = 32'h0; mem_d = 32'h0; wb_d = 32'h0;
    check("snap_if", snap_if, 32'h0000_0040);
    check("snap_id", snap_id, 32'hA1A1_0001);
    check("snap_ex", snap_ex, 32'hE3E3_0003);
    check("snap_mem", snap_mem, 32'hCAFE_0004);
    check("snap_wb", snap_wb, 32'h5555_0005);
    wait_frame_done(ok);
    check("frame1_done_seen", ok, 1);
    check("done_drawer_resetn", drawer_resetn, 0);
    check("done_plot", vga_plot, 0);
    check("snap_if_stable", snap_if, 32'h0000_0040);
    @(negedge clock);
    check("frame_done_pulse", frame_done, 0);
    check("wait_busy", busy, 0);
    check("frame1_plots", plot_cnt, CW * CH + 5);
    check("frame1_queue_empty", exp_q.size(), 0);
    check("frame1_fd_cnt", fd_cnt, 1);

    // force_refresh in WAIT starts a frame on the next edge
    n_pix = 60;
    force_refresh = 1'b1;
    @(negedge clock);
    force_refresh = 1'b0;
    check("force_in_wait_busy", busy, 1);
    wait_draw(ok);
    check("frame2_draw_seen", ok, 1);
    // Held 50 cycles in DRAW: exactly one extra frame after DONE
    force_refresh = 1'b1;
    repeat (50) @(negedge clock);
    force_refresh = 1'b0;
    wait_frame_done(ok);
    check("frame2_done_seen", ok, 1);
    measure_idle(cnt, ok);
    check("pending_frame_seen", ok, 1);
    check("pending_gap", cnt, 1);
    n_pix = 5;
    wait_frame_done(ok);
    check("frame3_done_seen", ok, 1);
    measure_idle(cnt, ok);
    check("no_second_extra_seen", ok, 1);
    check("no_second_extra_gap", cnt, RC);
    check("fd_cnt_3", fd_cnt, 3);

    // Drawer hangs: timeout after TO DRAW cycles
    hang = 1'b1;
    wait_draw(ok);
    check("hang_draw_seen", ok, 1);
    check("timeout_clear_before", draw_timeout, 0);
    dc = 1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
      if (drawer_resetn) dc++;
    end
    check("hang_done_seen", ok, 1);
    check("hang_draw_cycles", dc, TO);
    check("timeout_set", draw_timeout, 1);
    hang = 1'b0;

    // Next frame proceeds normally; timeout flag stays set
    measure_idle(cnt, ok);
    check("after_timeout_gap", cnt, RC);
    wait_frame_done(ok);
    check("after_timeout_done_seen", ok, 1);
    check("timeout_sticky", draw_timeout, 1);
    check("after_timeout_queue_empty", exp_q.size(), 0);

    // Reset during CLEAR after the 5th plot
    measure_idle(cnt, ok);
    check("mid_reset_frame_seen", ok, 1);
    pc = 0;
    for (int i = 0; i < 100 && pc < 5; i++) begin
      @(negedge clock);
      if (vga_plot) pc++;
    end
    check("mid_reset_plot5", pc, 5);
    #2 resetn = 1'b0;
    #1;
    check("mid_reset_plot", vga_plot, 0);
    check("mid_reset_drawer", drawer_resetn, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_timeout", draw_timeout, 0);
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    measure_idle(cnt, ok);
    check("post_reset_snap_seen", ok, 1);
    check("post_reset_idle", cnt, RC - 1);
    wait_frame_done(ok);
    check("post_reset_done_seen", ok, 1);
    @(negedge clock);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
